// File: rtl/cpu_pkg.sv
// Shared pipeline definitions: datapath/register-file widths, the register-zero
// address, the writeback source select encoding and a counter step helper.
// Used by the MEM/WB stage register, the writeback register file and its bus.
package cpu_pkg;

    localparam int DATA_W   = 32;
    localparam int ADDR_W   = 5;
    localparam int NUM_REGS = 32;
    localparam int CNT_W    = 32;

    // Address of the hardwired-zero register.
    localparam logic [ADDR_W-1:0] REG_ZERO = '0;

    // Writeback value source as encoded by the m2reg control bit.
    typedef enum logic {
        SEL_ALU = 1'b0,
        SEL_MEM = 1'b1
    } wb_src_e;

    // Free-running event counter step; wraps naturally at the top of its range.
    function automatic logic [CNT_W-1:0] count_next(input logic [CNT_W-1:0] count,
                                                    input logic             inc);
        return count + {{(CNT_W-1){1'b0}}, inc};
    endfunction

endpackage

// File: rtl/wb_regfile_if.sv
// Bus between the MEM/WB pipeline register, the ID stage and the writeback
// register file. The master side drives writeback fields and read addresses;
// the slave side (the register file) returns read data, the selected
// writeback value and the retirement counters.
interface wb_regfile_if #(
    parameter int DATA_W = cpu_pkg::DATA_W,
    parameter int ADDR_W = cpu_pkg::ADDR_W
);

    logic                       wb_wreg;
    logic                       wb_m2reg;
    logic [DATA_W-1:0]          wb_mo;
    logic [DATA_W-1:0]          wb_alu;
    logic [ADDR_W-1:0]          wb_rn;
    logic                       wb_branch;
    logic [ADDR_W-1:0]          rna;
    logic [ADDR_W-1:0]          rnb;
    logic [DATA_W-1:0]          qa;
    logic [DATA_W-1:0]          qb;
    logic [DATA_W-1:0]          wb_data;
    logic [cpu_pkg::CNT_W-1:0]  wr_count;
    logic [cpu_pkg::CNT_W-1:0]  br_count;

    modport master (
        output wb_wreg, wb_m2reg, wb_mo, wb_alu, wb_rn, wb_branch, rna, rnb,
        input  qa, qb, wb_data, wr_count, br_count
    );

    modport slave (
        input  wb_wreg, wb_m2reg, wb_mo, wb_alu, wb_rn, wb_branch, rna, rnb,
        output qa, qb, wb_data, wr_count, br_count
    );

endinterface

// File: rtl/wb_regfile_wb_select.sv
// Writeback value select: chooses memory load data or the ALU result
// according to the m2reg control bit. Purely combinational.
module wb_select #(
    parameter int DATA_W = cpu_pkg::DATA_W
) (
    input  logic              m2reg,
    input  logic [DATA_W-1:0] mo,
    input  logic [DATA_W-1:0] alu,
    output logic [DATA_W-1:0] data
);
    import cpu_pkg::*;

    // Pick the writeback source every cycle, whether or not a write happens.
    always_comb begin
        data = alu;
        case (wb_src_e'(m2reg))
            SEL_MEM: data = mo;
            default: data = alu;
        endcase
    end

endmodule

// File: rtl/wb_regfile.sv
// Writeback-stage register file: commits the selected writeback value into a
// 2^ADDR_W x DATA_W register array (register 0 hardwired to zero), serves two
// combinational ID-stage read ports and counts committed writes and retired
// branches. clr is an asynchronous active-high clear.
// Optional feature: define WB_BYPASS_EN for same-cycle write-through from the
// WB write port to both read ports; without it reads return the stored value.
module wb_regfile #(
    parameter int DATA_W = cpu_pkg::DATA_W,
    parameter int ADDR_W = cpu_pkg::ADDR_W
) (
    input  logic         clk,
    input  logic         clr,
    wb_regfile_if.slave  bus
);
    import cpu_pkg::*;

    localparam int DEPTH = 1 << ADDR_W;

    logic [DATA_W-1:0] regs [DEPTH];
    logic [DATA_W-1:0] wb_data;
    logic              commit;
    logic [CNT_W-1:0]  wr_count_q;
    logic [CNT_W-1:0]  br_count_q;
    logic [DATA_W-1:0] qa;
    logic [DATA_W-1:0] qb;

    wb_select #(
        .DATA_W (DATA_W)
    ) u_select (
        .m2reg (bus.wb_m2reg),
        .mo    (bus.wb_mo),
        .alu   (bus.wb_alu),
        .data  (wb_data)
    );

    // A write commits only when enabled, aimed at a real register and not in reset.
    always_comb begin
        commit = bus.wb_wreg && (bus.wb_rn != REG_ZERO) && !clr;
    end

    // Register array; entry 0 is cleared on reset and never written, so it stays zero.
    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            for (int i = 0; i < DEPTH; i++) begin
                regs[i] <= '0;
            end
        end else if (commit) begin
            regs[bus.wb_rn] <= wb_data;
        end
    end

    // Read ports: zero for r0 or during reset, optional write-through from WB.
    always_comb begin
        qa = '0;
        qb = '0;
        if (!clr && (bus.rna != REG_ZERO)) begin
            qa = regs[bus.rna];
`ifdef WB_BYPASS_EN
            if (commit && (bus.rna == bus.wb_rn)) begin
                qa = wb_data;
            end
`endif
        end
        if (!clr && (bus.rnb != REG_ZERO)) begin
            qb = regs[bus.rnb];
`ifdef WB_BYPASS_EN
            if (commit && (bus.rnb == bus.wb_rn)) begin
                qb = wb_data;
            end
`endif
        end
    end

    // Committed-write counter; wraps silently.
    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            wr_count_q <= '0;
        end else begin
            wr_count_q <= count_next(wr_count_q, commit);
        end
    end

    // Retired-branch counter, independent of the write enable; wraps silently.
    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            br_count_q <= '0;
        end else begin
            br_count_q <= count_next(br_count_q, bus.wb_branch);
        end
    end

    assign bus.qa       = qa;
    assign bus.qb       = qb;
    assign bus.wb_data  = wb_data;
    assign bus.wr_count = wr_count_q;
    assign bus.br_count = br_count_q;

endmodule
